// File: rtl/byte_data_memory.sv
// Byte-addressable 32-bit data memory with valid/ready load/store handshake and self-initialisation.
// Optional macro DMEM_MISALIGN_ERR_EN: flag misaligned/illegal accesses instead of forcing alignment.
module byte_data_memory #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [31:0]      mem_q [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             is_byte, is_half, is_word, sext;
  logic             access_err, accept, mem_we;
  logic [31:0]      rd_word, ld_data, wr_data;
  logic [7:0]       sel_b;
  logic [15:0]      sel_h;
  logic [3:0]       wr_be;

  if (ADDR_W > IDX_W + 2) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];
  end

  // Request decode, load lane extraction and store lane steering
  always_comb begin
    idx     = req_addr[IDX_W+1:2];
    lane    = req_addr[1:0];
    is_byte = (req_size[1:0] == 2'b00);
    is_half = (req_size[1:0] == 2'b01);
    is_word = req_size[1];
    sext    = ~req_size[2];
`ifdef DMEM_MISALIGN_ERR_EN
    access_err = (req_size == 3'b011) || (req_size[2:1] == 2'b11) ||
                 (is_half && lane[0]) || (is_word && (lane != 2'b00));
`else
    access_err = 1'b0;
    if (is_half) lane[0] = 1'b0;
    if (is_word) lane = 2'b00;
`endif
    rd_word = mem_q[idx];
    sel_b   = rd_word[{lane, 3'b000} +: 8];
    sel_h   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = rd_word;
    wr_data = req_wdata;
    wr_be   = 4'b1111;
    if (is_byte) begin
      ld_data = {{24{sext & sel_b[7]}}, sel_b};
      wr_data = {4{req_wdata[7:0]}};
      wr_be   = 4'b0001 << lane;
    end else if (is_half) begin
      ld_data = {{16{sext & sel_h[15]}}, sel_h};
      wr_data = {2{req_wdata[15:0]}};
      wr_be   = lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign req_ready = (state_q == ST_READY) && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;
  assign mem_we    = accept && req_we && !access_err;

  // Next-state: init sequencing and response register
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
    if (accept) begin
      resp_valid_d = 1'b1;
      rdata_d      = (req_we || access_err) ? 32'd0 : ld_data;
      err_d        = access_err;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Storage: init pattern fill, then byte-enabled stores
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= 32'(cnt_q);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign init_done  = (state_q == ST_READY);

endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: behavioural memory model checked every cycle, directed
// literal scenarios, randomized traffic with backpressure, and mid-operation reset.
module tb_byte_data_memory;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 8;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              init_done;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  byte_data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference memory: byte-lane arithmetic on whole words
  logic [31:0] mem_m [DEPTH];

  function automatic void model_access(input logic we, input logic [2:0] size,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int nb;
    int lane;
    logic [IDX_W-1:0] idx;
    logic [31:0] w;
    logic [31:0] mask;
    bit sgn;
    idx  = addr[IDX_W+1:2];
    lane = int'(addr[1:0]);
    case (size)
      3'b000, 3'b100: nb = 1;
      3'b001, 3'b101: nb = 2;
      default:        nb = 4;
    endcase
    sgn   = (size == 3'b000) || (size == 3'b001);
    rdata = 32'd0;
    err   = 1'b0;
    if (ERR_EN) begin
      if (size == 3'b011 || size == 3'b110 || size == 3'b111 || (lane % nb) != 0) begin
        err = 1'b1;
        return;
      end
    end else begin
      lane = lane - (lane % nb);
    end
    w = mem_m[idx];
    if (we) begin
      for (int b = 0; b < nb; b++) w[8*(lane+b) +: 8] = wdata[8*b +: 8];
      mem_m[idx] = w;
    end else begin
      mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      rdata = (w >> (8*lane)) & mask;
      if (sgn && rdata[8*nb-1]) rdata = rdata | ~mask;
    end
  endfunction

  // Cycle model of handshake state plus per-cycle comparison
  bit          m_started = 1'b0;
  bit          m_ready   = 1'b0;
  bit          m_valid   = 1'b0;
  bit          m_err     = 1'b0;
  logic [31:0] m_rdata   = 32'd0;
  int          m_cnt     = 0;

  always @(negedge clk) begin
    bit          exp_ready;
    logic [31:0] rd;
    logic        er;
    exp_ready = m_ready && (!m_valid || resp_ready);
    if (m_started) begin
      check("resp_valid", 32'(resp_valid), 32'(m_valid));
      check("init_done",  32'(init_done),  32'(m_ready));
      check("req_ready",  32'(req_ready),  32'(exp_ready));
      if (m_valid) begin
        check("resp_rdata", resp_rdata, m_rdata);
        check("resp_err",   32'(resp_err), 32'(m_err));
      end
    end
    if (rst) begin
      m_started = 1'b1;
      m_ready   = 1'b0;
      m_cnt     = 0;
      m_valid   = 1'b0;
      m_rdata   = 32'd0;
      m_err     = 1'b0;
    end else if (!m_ready) begin
      mem_m[IDX_W'(m_cnt)] = 32'(m_cnt);
      if (m_cnt == DEPTH - 1) m_ready = 1'b1;
      m_cnt++;
    end else if (req_valid && exp_ready) begin
      model_access(req_we, req_size, req_addr, req_wdata, rd, er);
      m_valid = 1'b1;
      m_rdata = rd;
      m_err   = er;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit rnd_rr);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    while (!done) begin
      @(negedge clk);
      done = req_ready;
      tick();
      if (rnd_rr) resp_ready = 1'($urandom_range(0, 1));
      n++;
      if (!done && n > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: request not accepted after %0d cycles, addr 0x%08h", n, addr);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input bit rnd_rr);
    req_valid = 1'b0;
    tick();
    if (rnd_rr) resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_resp(input string name, input logic [31:0] exp_rdata, input logic exp_err);
    check({name, "_valid"}, 32'(resp_valid), 32'd1);
    check({name, "_rdata"}, resp_rdata, exp_rdata);
    check({name, "_err"},   32'(resp_err), 32'(exp_err));
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done && n < 1000) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    logic [31:0] a;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 3'b000;
    req_addr   = '0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_init_done",  32'(init_done),  32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata,      32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    wait_init("init_cycles");

    send(1'b0, 3'b010, 32'h40, 32'd0, 1'b0);        check_resp("lw_40", 32'h0000_0010, 1'b0);
    send(1'b1, 3'b000, 32'h11, 32'h1234_56A5, 1'b0); check_resp("sb_11", 32'd0, 1'b0);
    send(1'b0, 3'b010, 32'h10, 32'd0, 1'b0);        check_resp("lw_10", 32'h0000_A504, 1'b0);
    send(1'b0, 3'b000, 32'h11, 32'd0, 1'b0);        check_resp("lb_11", 32'hFFFF_FFA5, 1'b0);
    send(1'b0, 3'b100, 32'h11, 32'd0, 1'b0);        check_resp("lbu_11", 32'h0000_00A5, 1'b0);
    send(1'b1, 3'b001, 32'h22, 32'hCAFE_8001, 1'b0); check_resp("sh_22", 32'd0, 1'b0);
    send(1'b0, 3'b001, 32'h22, 32'd0, 1'b0);        check_resp("lh_22", 32'hFFFF_8001, 1'b0);
    send(1'b0, 3'b101, 32'h22, 32'd0, 1'b0);        check_resp("lhu_22", 32'h0000_8001, 1'b0);
    send(1'b0, 3'b010, 32'h20, 32'd0, 1'b0);        check_resp("lw_20", 32'h8001_0008, 1'b0);
    idle(1'b0);

    // Backpressure: response held, no new acceptance
    resp_ready = 1'b0;
    send(1'b0, 3'b010, 32'h0C, 32'd0, 1'b0);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check_resp("stall_lw_0c", 32'h0000_0003, 1'b0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("stall_drain", 32'(resp_valid), 32'd0);

    // Misaligned / illegal accesses
    send(1'b0, 3'b010, 32'h42, 32'd0, 1'b0);
    check_resp("lw_42", ERR_EN ? 32'd0 : 32'h0000_0010, ERR_EN);
    send(1'b1, 3'b010, 32'h41, 32'hDEAD_BEEF, 1'b0);
    check_resp("sw_41", 32'd0, ERR_EN);
    send(1'b0, 3'b010, 32'h40, 32'd0, 1'b0);
    check_resp("lw_40_after", ERR_EN ? 32'h0000_0010 : 32'hDEAD_BEEF, 1'b0);
    send(1'b0, 3'b001, 32'h23, 32'd0, 1'b0);
    check_resp("lh_23", ERR_EN ? 32'd0 : 32'hFFFF_8001, ERR_EN);
    send(1'b0, 3'b011, 32'h20, 32'd0, 1'b0);
    check_resp("size011", ERR_EN ? 32'd0 : 32'h8001_0008, ERR_EN);
    idle(1'b0);

    // Random traffic over 16 aliased words with random backpressure
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      a[IDX_W+1:2] = IDX_W'($urandom_range(0, 15));
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1'b1);
    end
    resp_ready = 1'b1;
    repeat (3) idle(1'b0);

    // Reset while a response is pending
    resp_ready = 1'b0;
    send(1'b0, 3'b010, 32'h10, 32'd0, 1'b0);
    req_valid = 1'b0;
    check("pre_rst_valid", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_drop_valid", 32'(resp_valid), 32'd0);
    check("rst_drop_init",  32'(init_done),  32'd0);
    resp_ready = 1'b1;
    wait_init("reinit_cycles");
    send(1'b0, 3'b010, 32'h10, 32'd0, 1'b0);
    check_resp("reinit_lw_10", 32'h0000_0004, 1'b0);
    repeat (3) idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning memory size in 32-bit words (power of 2, at least 4).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width (at least log2(DEPTH)+2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: request present.
REQ-006 SHALL have port req_ready, output, 1 bit: request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 3 bits: RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-009 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: response present.
REQ-012 SHALL have port resp_ready, input, 1 bit: response consumed when high with resp_valid.
REQ-013 SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores.
REQ-014 SHALL have port resp_err, output, 1 bit: misaligned or illegal access.
REQ-015 SHALL have port init_done, output, 1 bit: initialisation complete.

Function
REQ-016 SHALL index words by req_addr[log2(DEPTH)+1:2]; higher address bits ignored (aliasing).
REQ-017 SHALL use two-state FSM: INIT -> READY when init counter reaches DEPTH-1; READY holds until rst.
REQ-018 SHALL, in INIT, write mem[i] = i (i = counter, 0..DEPTH-1) one word per cycle, taking exactly DEPTH cycles; init_done = 1 only in READY.
REQ-019 SHALL drive req_ready = (state == READY) and (not resp_valid or resp_ready).
REQ-020 SHALL, on acceptance, register response so resp_valid is high the next cycle (1-cycle latency); back-to-back accepts allowed when resp_ready = 1.
REQ-021 SHALL hold resp_rdata and resp_err stable while resp_valid = 1 and resp_ready = 0.
REQ-022 SHALL select load lane by addr[1:0]: lb/lh sign-extend, lbu/lhu zero-extend, lw full word.
REQ-023 SHALL write stores at the acceptance edge, byte-enabled: sb one lane at addr[1:0], sh lanes addr[1]*2..+1, sw all four lanes; other lanes unchanged.
REQ-024 SHALL return store-updated data for a load accepted the cycle after the store to the same word.
REQ-025 SHALL treat req_size 011/110/111 as illegal when DMEM_MISALIGN_ERR_EN is defined, and as 010 otherwise.

Reset
REQ-026 SHALL, on rst, clear resp_valid, resp_rdata, resp_err, init_done and init counter to 0, and enter INIT.
REQ-027 SHALL, on rst mid-operation, drop any pending response and re-run the full init, overwriting prior stores.

Configuration
REQ-028 SHALL, with DMEM_MISALIGN_ERR_EN defined, flag misaligned (h with addr[0]=1; w with addr[1:0]!=0) or illegal accesses: no write, resp_err = 1, resp_rdata = 0.
REQ-029 SHALL, without DMEM_MISALIGN_ERR_EN, tie resp_err to 0 and force alignment (h ignores addr[0], w ignores addr[1:0]).

Verification
REQ-030 SHALL cover: release rst -> init_done high after 256 cycles; lw 0x40 -> rdata 0x00000010.
REQ-031 SHALL cover: sb 0xA5 at 0x11, then lw 0x10 -> 0x0000A504; lb 0x11 -> 0xFFFFFFA5; lbu 0x11 -> 0x000000A5.
REQ-032 SHALL cover: sh 0x8001 at 0x22, then lh 0x22 -> 0xFFFF8001; lw 0x20 -> 0x80010008.
REQ-033 SHALL cover: resp_ready low 3 cycles after lw 0x0C -> req_ready low, rdata stays 0x00000003.
REQ-034 SHALL cover: lw 0x42 -> with macro err = 1 and rdata 0; without macro rdata 0x00000010; sw 0x41 with macro leaves word 16 unchanged.
REQ-035 SHALL cover: rst pulsed while resp_valid = 1 -> resp_valid 0 next cycle; after re-init, lw 0x10 -> 0x00000004.
